pipe_hazard_ctrl: RTL

Central stall/flush scheduler for the 5-stage core. It detects load-use hazards, taken branch/jump redirects and data-memory wait, and drives the per-stage control vectors (sf) of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus PC hold. It owns the multi-cycle flush window that covers the one-cycle instruction-memory latency. It also keeps stall/flush event counters for debug.

---
 rtl/pipe_ctrl_pkg.sv | 18 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: the per-stage stall/flush
// control encoding and the scheduler state machine.
package pipe_ctrl_pkg;

  typedef logic [1:0] sf_t;

  localparam sf_t SF_RUN   = 2'b00;
  localparam sf_t SF_HOLD  = 2'b10;
  localparam sf_t SF_FLUSH = 2'b01;

  typedef enum logic [1:0] {
    RST_FLUSH,
    RUN,
    REDIRECT,
    MEM_WAIT
  } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the instruction in ID and a load in EX.
// Register x0 never creates a dependency.
module hazard_detect (
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [4:0] rd,
  input  logic       mem_read,
  output logic       hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = rs1_used && (rs1 == rd);
  assign rs2_match = rs2_used && (rs2 == rd);
  assign hazard    = mem_read && (rd != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler: load-use stalls, redirect flush windows,
// data-memory freeze, plus debug event counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REDIRECT_CYCLES  = 2,
  parameter int RST_FLUSH_CYCLES = 1,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             dm_busy,
  output logic             pc_hold,
  output logic [1:0]       if_id_sf,
  output logic [1:0]       id_ex_sf,
  output logic [1:0]       ex_mem_sf,
  output logic [1:0]       mem_wb_sf,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] RST_FCNT   = 3'(RST_FLUSH_CYCLES - 1);
  localparam logic [2:0] REDIR_FCNT = (REDIRECT_CYCLES > 1) ? 3'(REDIRECT_CYCLES - 2) : 3'd0;

  hz_state_t  state, state_n;
  hz_state_t  saved_state, saved_state_n;
  hz_state_t  eff_state;
  logic [2:0] fcnt, fcnt_n;
  logic       load_use;
  logic       redirect_take;

  hazard_detect u_hazard_detect (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs1_used (id_rs1_used),
    .rs2_used (id_rs2_used),
    .rd       (ex_rd),
    .mem_read (ex_mem_read),
    .hazard   (load_use)
  );

  // While frozen, the saved state decides what happens on the cycle dm_busy
  // drops, so the pipe resumes exactly where it stopped without a dead cycle.
  assign eff_state     = (state == MEM_WAIT) ? saved_state : state;
  assign redirect_take = !rst && !dm_busy && ex_redirect &&
                         ((eff_state == RUN) || (eff_state == REDIRECT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RST_FLUSH;
      saved_state <= RUN;
      fcnt        <= RST_FCNT;
    end else begin
      state       <= state_n;
      saved_state <= saved_state_n;
      fcnt        <= fcnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    saved_state_n = saved_state;
    fcnt_n        = fcnt;
    case (eff_state)
      RST_FLUSH: begin
        if (fcnt == 3'd0) state_n = RUN;
        else              fcnt_n  = fcnt - 3'd1;
      end
      RUN, REDIRECT: begin
        if (dm_busy) begin
          state_n       = MEM_WAIT;
          saved_state_n = eff_state;
        end else if (ex_redirect) begin
          if (REDIRECT_CYCLES > 1) begin
            state_n = REDIRECT;
            fcnt_n  = REDIR_FCNT;
          end else begin
            state_n = RUN;
          end
        end else if (eff_state == REDIRECT) begin
          if (fcnt == 3'd0) begin
            state_n = RUN;
          end else begin
            state_n = REDIRECT;
            fcnt_n  = fcnt - 3'd1;
          end
        end else begin
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    pc_hold   = 1'b0;
    if_id_sf  = SF_RUN;
    id_ex_sf  = SF_RUN;
    ex_mem_sf = SF_RUN;
    mem_wb_sf = SF_RUN;
    if (rst) begin
      if_id_sf  = SF_FLUSH;
      id_ex_sf  = SF_FLUSH;
      ex_mem_sf = SF_FLUSH;
      mem_wb_sf = SF_FLUSH;
    end else begin
      case (eff_state)
        RST_FLUSH: if_id_sf = SF_FLUSH;
        RUN, REDIRECT: begin
          if (dm_busy) begin
            pc_hold   = 1'b1;
            if_id_sf  = SF_HOLD;
            id_ex_sf  = SF_HOLD;
            ex_mem_sf = SF_HOLD;
            mem_wb_sf = SF_HOLD;
          end else if (ex_redirect) begin
            if_id_sf = SF_FLUSH;
            id_ex_sf = SF_FLUSH;
          end else if (eff_state == REDIRECT) begin
            if_id_sf = SF_FLUSH;
          end else if (load_use) begin
            pc_hold  = 1'b1;
            if_id_sf = SF_HOLD;
            id_ex_sf = SF_FLUSH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_hold)       stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_take) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
